cipher_round_mod: RTL and testbench
===================================

CIPHER_ROUND_MOD -- requirements
Module: cipher_round_mod

Interface
REQ-001 The block SHALL have the port clk, an input, 1 bit wide, which is the clock; all registers use its rising edge.
REQ-002 The block SHALL have the port reset_n, an input, 1 bit wide; reset is reset_n, asynchronous, active-low.
REQ-003 The block SHALL have the port last_cipher_iteration, an input, 1 bit wide; 1 selects a final round, which skips MixColumns.
REQ-004 The block SHALL have the port StateIn, an input, 128 bits wide, carrying the AES state; byte i = StateIn[8i+7:8i].
REQ-005 The block SHALL have the port Roundkey, an input, 128 bits wide, carrying the round key, using the same byte order as StateIn.
REQ-006 The block SHALL have the port StateOut, an output, 128 bits wide, carrying the round result, using the same byte order as StateIn.
REQ-007 The block SHALL have no parameters.

Function
REQ-008 The block SHALL map byte i of the state to row i mod 4 and column i div 4 (x86 AESENC layout: byte 0 = LSB).
REQ-009 The block SHALL apply SubBytes with the FIPS-197 forward S-box to all 16 bytes, e.g. S(00)=63, S(01)=7c, S(ff)=16.
REQ-010 The block SHALL apply ShiftRows, in which row r rotates left by r columns: new[r][c] = old[r][(c+r) mod 4].
REQ-011 The block SHALL apply MixColumns when last_cipher_iteration=0, using the matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8) with polynomial 0x11b.
REQ-012 The block SHALL implement xtime(b) as (b<<1) XOR (0x1b if b[7]=1), truncated to 8 bits.
REQ-013 The block SHALL bypass MixColumns when last_cipher_iteration=1.
REQ-014 The block SHALL set StateOut to the MixColumns-stage result XOR Roundkey, which is exactly AESENC when last_cipher_iteration=0 and AESENCLAST when it is 1.
REQ-015 The datapath SHALL be purely combinational from StateIn/Roundkey/last_cipher_iteration to the output stage, with no latches.
REQ-016 The block SHALL have no handshake; it accepts a new input every cycle and never stalls.

Reset
REQ-017 In combinational mode (macro undefined), reset_n and clk SHALL have no effect on StateOut.
REQ-018 In registered mode, reset_n=0 SHALL asynchronously force StateOut to 128'h0.
REQ-019 In registered mode, reset asserted mid-stream SHALL discard any in-flight result.
REQ-020 In registered mode, the first valid result after reset_n deasserts SHALL appear one clk edge after it is applied.

Configuration
REQ-021 The block SHALL use the macro CIPHER_ROUND_OUTREG_EN.
REQ-022 When CIPHER_ROUND_OUTREG_EN is defined, StateOut SHALL be registered on the rising edge of clk, giving a latency of exactly 1 cycle and a throughput of 1 per cycle.
REQ-023 When CIPHER_ROUND_OUTREG_EN is undefined, StateOut SHALL be combinational with 0-cycle latency.
REQ-024 The macro SHALL change only the latency; the functional result is identical in both modes.

Verification
REQ-025 The bench SHALL check: StateIn=0, Roundkey=0, last=0 -> StateOut=128'h63636363636363636363636363636363.
REQ-026 The bench SHALL check: StateIn=128'h0101…01, Roundkey=128'hffff…ff, last=0 -> StateOut=128'h8383…83.
REQ-027 The bench SHALL check: StateIn=128'h7b5b54657374566563746f725d53475d, Roundkey=128'h48692853686179295b477565726f6e5d, last=0 -> StateOut=128'ha8311c2f9fdba3c58b104b58ded7e595.
REQ-028 The bench SHALL check: the same StateIn/Roundkey as REQ-027 with last=1 -> StateOut=128'hc7fb881e938c5964177ec42553fdc611.
REQ-029 The bench SHALL check in registered mode: with reset_n=0 -> StateOut=0 immediately (asynchronous), without waiting for a clk edge.
REQ-030 The bench SHALL check in registered mode: after reset_n=1, apply the vectors of REQ-027 and REQ-028 on consecutive cycles -> the matching results appear on the next cycles, back-to-back.
REQ-031 The bench SHALL check in registered mode: assert reset_n=0 mid-stream -> StateOut=0 at once, and after reset_n=1 the next result is correct with 1-cycle latency.

Source files
------------

// File: rtl/cipher_round_mod.sv
// cipher_round_mod: one AES encryption round (AESENC / AESENCLAST).
//   StateOut = MixColumns?(ShiftRows(SubBytes(StateIn))) ^ Roundkey,
//   with MixColumns skipped when last_cipher_iteration is high.
// Byte i of every 128-bit bus is bits [8i+7:8i]; byte i sits at row i%4,
// column i/4 (x86 layout, byte 0 = LSB).
// Optional output register: define CIPHER_ROUND_OUTREG_EN to register
// StateOut (1-cycle latency, async active-low reset to zero). Undefined,
// the block is purely combinational and clk/reset_n are ignored.
// Ports:
//   clk                   - clock, rising edge (registered mode only)
//   reset_n               - async active-low reset (registered mode only)
//   last_cipher_iteration - 1 = final round, no MixColumns
//   StateIn  [127:0]      - input state
//   Roundkey [127:0]      - round key
//   StateOut [127:0]      - round result
module cipher_round_mod (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         last_cipher_iteration,
  input  logic [127:0] StateIn,
  input  logic [127:0] Roundkey,
  output logic [127:0] StateOut
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned NUM_COLS  = 4;
  localparam int unsigned STATE_W   = BYTE_W * NUM_BYTES;

  // FIPS-197 forward S-box
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) mod 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [BYTE_W-1:0]  sub_bytes [NUM_BYTES];
  logic [BYTE_W-1:0]  shifted   [NUM_BYTES];
  logic [BYTE_W-1:0]  mixed     [NUM_BYTES];
  logic [STATE_W-1:0] round_c;

  // SubBytes on all 16 bytes
  always_comb begin : sub_stage
    for (int i = 0; i < NUM_BYTES; i++) begin
      sub_bytes[i] = SBOX[StateIn[BYTE_W*i +: BYTE_W]];
    end
  end

  // ShiftRows: row r rotates left by r columns
  always_comb begin : shift_stage
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[4*c + r] = sub_bytes[4*((c + r) % 4) + r];
      end
    end
  end

  // MixColumns on each 4-byte column
  always_comb begin : mix_stage
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < NUM_COLS; c++) begin
      a0 = shifted[4*c];
      a1 = shifted[4*c + 1];
      a2 = shifted[4*c + 2];
      a3 = shifted[4*c + 3];
      mixed[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mixed[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mixed[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mixed[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  // Final-round bypass and AddRoundKey
  always_comb begin : key_stage
    round_c = STATE_W'(0);
    for (int i = 0; i < NUM_BYTES; i++) begin
      round_c[BYTE_W*i +: BYTE_W] = (last_cipher_iteration ? shifted[i] : mixed[i])
                                    ^ Roundkey[BYTE_W*i +: BYTE_W];
    end
  end

`ifdef CIPHER_ROUND_OUTREG_EN
  // Output register; reset discards any in-flight result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StateOut <= STATE_W'(0);
    end else begin
      StateOut <= round_c;
    end
  end
`else
  // Clock and reset have no role in the combinational build
  logic unused;
  assign unused   = clk ^ reset_n;
  assign StateOut = round_c;
`endif

endmodule

// File: tb/tb_cipher_round_mod.sv
// Self-checking bench for cipher_round_mod. Reference model works on a 4x4
// byte matrix with a generic GF(2^8) multiply and an S-box derived from the
// field inverse plus affine transform. Build with CIPHER_ROUND_OUTREG_EN
// defined to exercise the registered variant.
module tb_cipher_round_mod;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         last = 1'b0;
  logic [127:0] state_in = '0;
  logic [127:0] round_key = '0;
  logic [127:0] state_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sbox_tab [256];

  localparam logic [127:0] V3_STATE = 128'h7b5b54657374566563746f725d53475d;
  localparam logic [127:0] V3_KEY   = 128'h48692853686179295b477565726f6e5d;
  localparam logic [127:0] V3_ENC   = 128'ha8311c2f9fdba3c58b104b58ded7e595;
  localparam logic [127:0] V3_LAST  = 128'hc7fb881e938c5964177ec42553fdc611;

  cipher_round_mod dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .last_cipher_iteration (last),
    .StateIn               (state_in),
    .Roundkey              (round_key),
    .StateOut              (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Shift-and-add multiply in GF(2^8) mod 0x11b
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? (8'({x, 1'b0}) ^ 8'h1b) : 8'({x, 1'b0});
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box = affine(inverse(x)), inverse found by exhaustive search
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] key,
                                             input logic fin);
    int base[4] = '{2, 3, 1, 1};
    logic [7:0] g [4][4];
    logic [7:0] h [4][4];
    logic [7:0] acc;
    logic [127:0] res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        g[r][c] = sbox_tab[st[8*(4*c + r) +: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        h[r][c] = g[r][(c + r) % 4];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (fin) begin
          acc = h[r][c];
        end else begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc ^= gmul(8'(base[(k - r + 4) % 4]), h[k][c]);
        end
        res[8*(4*c + r) +: 8] = acc ^ key[8*(4*c + r) +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return '1;
      default: return {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  task automatic drive(input logic [127:0] s, input logic [127:0] k, input logic l);
    state_in  = s;
    round_key = k;
    last      = l;
  endtask

  initial begin
    logic [127:0] s, k, exp;
    logic l;
    build_sbox();

`ifdef CIPHER_ROUND_OUTREG_EN
    // Asynchronous reset before any clock edge
    drive(V3_STATE, V3_KEY, 1'b0);
    #1 reset_n = 1'b0;
    #1 check("rst_async", state_out, 128'h0);
    @(posedge clk); #1;
    check("rst_held", state_out, 128'h0);
    // Known vectors back-to-back
    reset_n = 1'b1;
    drive('0, '0, 1'b0);
    @(posedge clk); #1;
    check("zero_vec", state_out, {16{8'h63}});
    drive({16{8'h01}}, {16{8'hff}}, 1'b0);
    @(posedge clk); #1;
    check("ones_vec", state_out, {16{8'h83}});
    drive(V3_STATE, V3_KEY, 1'b0);
    @(posedge clk); #1;
    check("aesenc_vec", state_out, V3_ENC);
    drive(V3_STATE, V3_KEY, 1'b1);
    @(posedge clk); #1;
    check("aesenclast_vec", state_out, V3_LAST);
    // Random stream, one per cycle
    for (int i = 0; i < 300; i++) begin
      s = rand128(); k = rand128(); l = 1'($urandom_range(0, 1));
      drive(s, k, l);
      exp = aes_round(s, k, l);
      @(posedge clk); #1;
      check("rand_reg", state_out, exp);
    end
    // Mid-stream reset with a result in flight
    drive(V3_STATE, V3_KEY, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("rst_mid", state_out, 128'h0);
    @(posedge clk); #1;
    check("rst_mid_discard", state_out, 128'h0);
    reset_n = 1'b1;
    drive(V3_STATE, V3_KEY, 1'b1);
    @(posedge clk); #1;
    check("post_rst_vec", state_out, V3_LAST);
    for (int i = 0; i < 20; i++) begin
      s = rand128(); k = rand128(); l = 1'($urandom_range(0, 1));
      drive(s, k, l);
      exp = aes_round(s, k, l);
      @(posedge clk); #1;
      check("post_rst_rand", state_out, exp);
    end
`else
    // Known vectors, zero latency
    drive('0, '0, 1'b0);
    #1 check("zero_vec", state_out, {16{8'h63}});
    drive({16{8'h01}}, {16{8'hff}}, 1'b0);
    #1 check("ones_vec", state_out, {16{8'h83}});
    drive(V3_STATE, V3_KEY, 1'b0);
    #1 check("aesenc_vec", state_out, V3_ENC);
    drive(V3_STATE, V3_KEY, 1'b1);
    #1 check("aesenclast_vec", state_out, V3_LAST);
    // Reset and clock must not disturb the combinational output
    reset_n = 1'b0;
    drive(V3_STATE, V3_KEY, 1'b0);
    #1 check("rst_ignored", state_out, V3_ENC);
    @(posedge clk); #1;
    check("rst_ignored_edge", state_out, V3_ENC);
    reset_n = 1'b1;
    #1 check("rst_release", state_out, V3_ENC);
    // Random inputs
    for (int i = 0; i < 300; i++) begin
      s = rand128(); k = rand128(); l = 1'($urandom_range(0, 1));
      drive(s, k, l);
      #2 check("rand_comb", state_out, aes_round(s, k, l));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
